// File: rtl/inst_mem.sv
// Instruction memory for the fetch stage: a combinational word read from a
// byte address, with a run-time programming port and a built-in default program.
module inst_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  misaligned,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         rd_index;
  logic [IW-1:0]         wr_index;
  logic                  unused_addr_bits;

  function automatic logic [DATA_WIDTH-1:0] default_word(input int index);
    logic [DATA_WIDTH-1:0] word;
    case (index)
      0:       word = 32'h0050_0093;
      1:       word = 32'h00A0_0113;
      2:       word = 32'h0020_81B3;
      3:       word = 32'h4020_8233;
      4:       word = 32'h0020_F2B3;
      5:       word = 32'h0020_E333;
      6:       word = 32'h0020_C3B3;
      default: word = 32'h0000_0013;
    endcase
    return word;
  endfunction

  // Byte offset and bits above the word index are dropped, so addresses wrap.
  assign rd_index = addr[2 +: IW];
  assign wr_index = prog_addr[2 +: IW];
  assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:2+IW],
                              prog_addr[ADDR_WIDTH-1:2+IW],
                              prog_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= default_word(i);
      end
    end else if (prog_we) begin
      mem[wr_index] <= prog_data;
    end
  end

  assign dout       = mem[rd_index];
  assign misaligned = |addr[1:0];

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: a table of read vectors plus hand-written
// sequences for programming, reset restore and reset/write collision.
module tb_inst_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] dout;
  logic        misaligned;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        mis;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  inst_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .dout      (dout),
    .misaligned(misaligned),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if (dout !== e.dout) begin
        failures++;
        $display("[TB] FAIL %s dout: got %08h expected %08h", e.name, dout, e.dout);
      end
      checks++;
      if (misaligned !== e.mis) begin
        failures++;
        $display("[TB] FAIL %s misaligned: got %0b expected %0b", e.name, misaligned, e.mis);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] exp_d,
                                input logic exp_m, input string name);
    exp_t e;
    e.dout = exp_d;
    e.mis  = exp_m;
    e.name = name;
    sb_q.push_back(e);
    addr = a;
    #1;
    check_output();
  endtask

  vec_t vecs[16];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'd0,        32'h0050_0093, 1'b0};
    vecs[1]  = '{32'd4,        32'h00A0_0113, 1'b0};
    vecs[2]  = '{32'd8,        32'h0020_81B3, 1'b0};
    vecs[3]  = '{32'd12,       32'h4020_8233, 1'b0};
    vecs[4]  = '{32'd16,       32'h0020_F2B3, 1'b0};
    vecs[5]  = '{32'd20,       32'h0020_E333, 1'b0};
    vecs[6]  = '{32'd24,       32'h0020_C3B3, 1'b0};
    vecs[7]  = '{32'd28,       32'h0000_0013, 1'b0};
    vecs[8]  = '{32'd32,       32'h0050_0093, 1'b0};
    vecs[9]  = '{32'd36,       32'h00A0_0113, 1'b0};
    vecs[10] = '{32'd40,       32'h0020_81B3, 1'b0};
    vecs[11] = '{32'd44,       32'h4020_8233, 1'b0};
    vecs[12] = '{32'd48,       32'h0020_F2B3, 1'b0};
    vecs[13] = '{32'd52,       32'h0020_E333, 1'b0};
    vecs[14] = '{32'd6,        32'h00A0_0113, 1'b1};
    vecs[15] = '{32'h8000_000C, 32'h4020_8233, 1'b0};

    rst_n     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    addr      = '0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);

    // Combinational read: each vector is driven and checked between edges.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].dout, vecs[i].mis, $sformatf("vec%0d", i));
      #9;
    end

    // Write 0x1C; the same word reads old before the edge and new right after.
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 32'h1C;
    prog_data = 32'hDEAD_BEEF;
    apply_stimulus(32'd28, 32'h0000_0013, 1'b0, "prog_before_edge");
    @(posedge clk);
    #1;
    apply_stimulus(32'd28, 32'hDEAD_BEEF, 1'b0, "prog_after_edge");
    @(negedge clk);
    prog_we = 1'b0;
    apply_stimulus(32'd60, 32'hDEAD_BEEF, 1'b0, "prog_wrap");
    apply_stimulus(32'd24, 32'h0020_C3B3, 1'b0, "prog_neighbour");

    // Reset mid-cycle restores the default image without any clock edge.
    #2;
    rst_n = 1'b0;
    apply_stimulus(32'd28, 32'h0000_0013, 1'b0, "reset_restore_low");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(32'd28, 32'h0000_0013, 1'b0, "reset_restore_released");

    // Reset held across an edge with a write pending: reset wins.
    @(negedge clk);
    rst_n     = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 32'h0;
    prog_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    apply_stimulus(32'd0, 32'h0050_0093, 1'b0, "collision_low");
    @(negedge clk);
    prog_we = 1'b0;
    rst_n   = 1'b1;
    apply_stimulus(32'd0, 32'h0050_0093, 1'b0, "collision_released");

    // First write after reset release lands on the next rising edge.
    rst_n = 1'b0;
    #2;
    rst_n     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 32'h26;
    prog_data = 32'hCAFE_F00D;
    apply_stimulus(32'd4, 32'h00A0_0113, 1'b0, "release_before_edge");
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    apply_stimulus(32'd5, 32'hCAFE_F00D, 1'b1, "release_first_write");
    apply_stimulus(32'd0, 32'h0050_0093, 1'b0, "release_other_word");

    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem.md
Name: inst_mem

Overview:
- Word-organised instruction memory feeding the fetch stage of the RISC-V core.
- Byte address in, 32-bit instruction word out; read is combinational, no clock latency.
- Contents come from a fixed built-in default program image, restored on reset.
- A synchronous programming port lets the bench or loader overwrite words at run time.

Parameters:
- ADDR_WIDTH, 32, width of the byte address input.
- DATA_WIDTH, 32, instruction word width. Fixed at 32.
- DEPTH, 8, number of words. Must be a power of two, at least 2. Index width IW = log2(DEPTH).

Ports:
- clk  input  1  clock; programming writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_WIDTH  fetch byte address.
- dout  output  DATA_WIDTH  instruction word at addr.
- misaligned  output  1  high when addr[1:0] != 0.
- prog_we  input  1  programming write enable.
- prog_addr  input  ADDR_WIDTH  programming byte address.
- prog_data  input  DATA_WIDTH  word to write.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Storage: DEPTH x 32 register array.
- Word index = addr[2 +: IW].
  - addr[1:0] does not affect dout.
  - Bits above 2+IW are ignored, so addresses wrap modulo DEPTH*4. For DEPTH=8, addr 32 reads word 0 and addr 52 reads word 5.
- Read path:
  - dout = mem[index], purely combinational, zero latency. dout follows addr within the same delta/timestep.
  - misaligned = |addr[1:0], combinational. It is a flag only; the read still uses the truncated index.
- Default image (DEPTH=8; for larger DEPTH, words 8 and above are 0x00000013):
  - w0 0x00500093, addi x1,x0,5
  - w1 0x00A00113, addi x2,x0,10
  - w2 0x002081B3, add x3,x1,x2
  - w3 0x40208233, sub x4,x1,x2
  - w4 0x0020F2B3, and x5,x1,x2
  - w5 0x0020E333, or x6,x1,x2
  - w6 0x0020C3B3, xor x7,x1,x2
  - w7 0x00000013, nop
- Reset:
  - rst_n low asynchronously loads the default image into every word, immediately and without a clock edge.
  - While rst_n is low, dout reflects the default image and writes are blocked.
- Programming write:
  - Occurs on rising clk when rst_n=1 and prog_we=1: mem[prog_addr[2 +: IW]] <= prog_data.
  - prog_addr[1:0] and the upper bits are ignored, with the same wrap rule as reads.
- Boundary conditions:
  - Read of the word being written: dout shows the old value before the edge and the new value immediately after it.
  - Reset asserted in the same cycle as prog_we: reset wins and the word holds its default.
  - Reset released: the first write can occur on the next rising edge with rst_n high.
  - X or Z on prog_we is treated as no write. The design is not required to detect this, and the bench must drive prog_we cleanly.
- No other state; no handshake; dout is always valid.

Test Plan:
- Reset pulse, then sweep addr = 0,4,...,28 with 10-time-unit spacing:
  - dout = w0..w7 exactly as listed; misaligned = 0.
- Wrap-around, addr = 32, 36, 40, 44, 48, 52:
  - dout = 0x00500093, 0x00A00113, 0x002081B3, 0x40208233, 0x0020F2B3, 0x0020E333.
- Misaligned and upper-bit ignore:
  - addr = 6 -> dout = 0x00A00113, misaligned = 1.
  - addr = 0x8000000C -> dout = 0x40208233, misaligned = 0.
- Programming:
  - prog_we=1, prog_addr=0x1C, prog_data=0xDEADBEEF at an edge.
  - addr=28 -> dout = 0xDEADBEEF.
  - addr=60 -> dout = 0xDEADBEEF.
  - addr=24 is unchanged at 0x0020C3B3.
- Reset restore:
  - After the programming test, pulse rst_n low mid-cycle with no clock edge.
  - addr=28 -> dout = 0x00000013 while rst_n is low, and it remains so after release.
- Reset vs write collision:
  - rst_n=0 with prog_we=1, prog_addr=0, prog_data=0x12345678 across an edge.
  - addr=0 -> dout = 0x00500093.
